// File: rtl/mul_div_unit_pkg.sv
// Shared encodings for the iterative MIPS multiply/divide unit.
package mul_div_unit_pkg;

  typedef enum logic [1:0] {
    OpMult  = 2'b00,
    OpMultu = 2'b01,
    OpDiv   = 2'b10,
    OpDivu  = 2'b11
  } md_op_e;

  typedef enum logic [2:0] {
    StIdle,
    StMul,
    StDiv,
    StFix,
    StDone
  } md_state_e;

  localparam int unsigned NumIters = 32;

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/completion and MTHI/MTLO/HI/LO bundle between pipeline control and the unit.
interface mul_div_unit_if #(
  parameter int unsigned DATA_WIDTH = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic [1:0]            op;
  logic [DATA_WIDTH-1:0] A;
  logic [DATA_WIDTH-1:0] B;
  logic                  flush;
  logic                  out_valid;
  logic                  out_ready;
  logic                  hi_we;
  logic                  lo_we;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] hi;
  logic [DATA_WIDTH-1:0] lo;

  modport master (
    output in_valid, op, A, B, flush, out_ready, hi_we, lo_we, wdata,
    input  in_ready, out_valid, hi, lo
  );

  modport slave (
    input  in_valid, op, A, B, flush, out_ready, hi_we, lo_we, wdata,
    output in_ready, out_valid, hi, lo
  );

endinterface

// File: rtl/mul_div_unit_md_step.sv
// One radix-2 iteration: mode 0 = conditional add then right shift of {acc,lo},
// mode 1 = left shift of {rem,quot}, trial subtract, restore on borrow.
module md_step #(
  parameter int unsigned W = 32
) (
  input  logic         mode_i,
  input  logic [W-1:0] acc_i,
  input  logic [W-1:0] lo_i,
  input  logic [W-1:0] opnd_i,
  output logic [W-1:0] acc_o,
  output logic [W-1:0] lo_o
);

  logic [W:0]   sum;
  logic [W:0]   shl;
  logic [W-1:0] diff;
  logic         fits;

  always_comb begin
    sum  = {1'b0, acc_i} + (lo_i[0] ? {1'b0, opnd_i} : '0);
    shl  = {acc_i, lo_i[W-1]};
    fits = shl >= {1'b0, opnd_i};
    // Modular difference is exact whenever the trial subtract fits.
    diff = shl[W-1:0] - opnd_i;
    if (mode_i) begin
      acc_o = fits ? diff : shl[W-1:0];
      lo_o  = {lo_i[W-2:0], fits};
    end else begin
      acc_o = sum[W:1];
      lo_o  = {sum[0], lo_i[W-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; magnitudes are iterated and
// signs are applied in a single FIX cycle so every op has the same latency.
module mul_div_unit
  import mul_div_unit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  md_state_e             state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [DATA_WIDTH-1:0] mplr_q, mplr_d;
  logic [DATA_WIDTH-1:0] opnd_q, opnd_d;
  logic                  is_div_q, is_div_d;
  logic                  neg_q, neg_d;
  logic                  sign_a_q, sign_a_d;
  logic                  b_zero_q, b_zero_d;
  logic [DATA_WIDTH-1:0] hi_q, hi_d;
  logic [DATA_WIDTH-1:0] lo_q, lo_d;

  md_op_e                  op_in;
  logic                    signed_op;
  logic                    sign_a;
  logic                    sign_b;
  logic [DATA_WIDTH-1:0]   abs_a;
  logic [DATA_WIDTH-1:0]   abs_b;
  logic [DATA_WIDTH-1:0]   step_acc;
  logic [DATA_WIDTH-1:0]   step_lo;
  logic [2*DATA_WIDTH-1:0] prod;

  assign op_in     = md_op_e'(bus.op);
  assign signed_op = (op_in == OpMult) || (op_in == OpDiv);
  assign sign_a    = signed_op & bus.A[DATA_WIDTH-1];
  assign sign_b    = signed_op & bus.B[DATA_WIDTH-1];
  assign abs_a     = sign_a ? ('0 - bus.A) : bus.A;
  assign abs_b     = sign_b ? ('0 - bus.B) : bus.B;

  md_step #(
    .W (DATA_WIDTH)
  ) u_step (
    .mode_i (is_div_q),
    .acc_i  (acc_q),
    .lo_i   (mplr_q),
    .opnd_i (opnd_q),
    .acc_o  (step_acc),
    .lo_o   (step_lo)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mplr_d   = mplr_q;
    opnd_d   = opnd_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    sign_a_d = sign_a_q;
    b_zero_d = b_zero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    prod     = {acc_q, mplr_q};

    unique case (state_q)
      StIdle: begin
        if (bus.hi_we) hi_d = bus.wdata;
        if (bus.lo_we) lo_d = bus.wdata;
        if (bus.in_valid && !bus.flush) begin
          acc_d    = '0;
          cnt_d    = '0;
          is_div_d = op_in[1];
          neg_d    = sign_a ^ sign_b;
          sign_a_d = sign_a;
          b_zero_d = (bus.B == '0);
          if (op_in[1]) begin
            mplr_d  = abs_a;
            opnd_d  = abs_b;
            state_d = StDiv;
          end else begin
            mplr_d  = abs_b;
            opnd_d  = abs_a;
            state_d = StMul;
          end
        end
      end
      StMul, StDiv: begin
        // The extra cycle at the terminal count pads latency to 34 edges.
        if (cnt_q == CNT_WIDTH'(NumIters)) begin
          state_d = StFix;
        end else begin
          acc_d  = step_acc;
          mplr_d = step_lo;
          cnt_d  = cnt_q + CNT_WIDTH'(1);
        end
      end
      StFix: begin
        if (is_div_q) begin
          lo_d = b_zero_q ? '1 : (neg_q ? ('0 - mplr_q) : mplr_q);
          hi_d = sign_a_q ? ('0 - acc_q) : acc_q;
        end else begin
          prod = neg_q ? ('0 - {acc_q, mplr_q}) : {acc_q, mplr_q};
          hi_d = prod[2*DATA_WIDTH-1:DATA_WIDTH];
          lo_d = prod[DATA_WIDTH-1:0];
        end
        state_d = StDone;
      end
      StDone: begin
        if (bus.out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    if (bus.flush && (state_q != StIdle)) begin
      state_d = StIdle;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      mplr_q   <= '0;
      opnd_q   <= '0;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      sign_a_q <= 1'b0;
      b_zero_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mplr_q   <= mplr_d;
      opnd_q   <= opnd_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      sign_a_q <= sign_a_d;
      b_zero_q <= b_zero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: transaction-level reference model checked every cycle,
// plus directed cases with hand-computed results.
module tb_mul_div_unit;

  localparam int MIdle = 0;
  localparam int MBusy = 1;
  localparam int MDone = 2;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   chk_en = 1'b0;

  int          m_state;
  int          m_left;
  logic [31:0] m_hi, m_lo, m_res_hi, m_res_lo;

  mul_div_unit_if #(.DATA_WIDTH(32)) bus ();

  mul_div_unit #(
    .DATA_WIDTH (32),
    .CNT_WIDTH  (6)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural results straight from MIPS arithmetic semantics.
  function automatic void ref_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] h, output logic [31:0] l);
    longint      p;
    logic [63:0] u;
    int          q, r;
    h = '0;
    l = '0;
    case (op)
      2'b00: begin
        p = longint'(int'(a)) * longint'(int'(b));
        u = p;
        h = u[63:32];
        l = u[31:0];
      end
      2'b01: begin
        u = {32'b0, a} * {32'b0, b};
        h = u[63:32];
        l = u[31:0];
      end
      2'b10: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF;
          h = a;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000;
          h = 32'h0;
        end else begin
          q = int'(a) / int'(b);
          r = int'(a) % int'(b);
          l = q;
          h = r;
        end
      end
      default: begin
        if (b == 0) begin
          l = 32'hFFFF_FFFF;
          h = a;
        end else begin
          l = a / b;
          h = a % b;
        end
      end
    endcase
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      m_state = MIdle;
      m_hi    = '0;
      m_lo    = '0;
    end else begin
      case (m_state)
        MIdle: begin
          if (bus.hi_we) m_hi = bus.wdata;
          if (bus.lo_we) m_lo = bus.wdata;
          if (bus.in_valid && !bus.flush) begin
            ref_op(bus.op, bus.A, bus.B, m_res_hi, m_res_lo);
            m_left  = 34;
            m_state = MBusy;
          end
        end
        MBusy: begin
          if (bus.flush) begin
            m_state = MIdle;
          end else begin
            m_left--;
            if (m_left == 0) begin
              m_hi    = m_res_hi;
              m_lo    = m_res_lo;
              m_state = MDone;
            end
          end
        end
        default: begin
          if (bus.flush || bus.out_ready) m_state = MIdle;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_in_ready", {31'b0, bus.in_ready}, {31'b0, m_state == MIdle});
      chk("model_out_valid", {31'b0, bus.out_valid}, {31'b0, m_state == MDone});
      chk("model_hi", bus.hi, m_hi);
      chk("model_lo", bus.lo, m_lo);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string name);
    int lat;
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.A        = a;
    bus.B        = b;
    step();
    bus.in_valid = 1'b0;
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      lat++;
      if (bus.out_valid) break;
    end
    chk({name, "_latency"}, 32'(lat), 32'd34);
    chk({name, "_hi"}, bus.hi, eh);
    chk({name, "_lo"}, bus.lo, el);
    if (bus.out_ready) step();
  endtask

  task automatic preload(input logic [31:0] h, input logic [31:0] l);
    bus.hi_we = 1'b1;
    bus.wdata = h;
    step();
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b1;
    bus.wdata = l;
    step();
    bus.lo_we = 1'b0;
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'h0;
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      3:       return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int c1, acc_cyc, lat;
    logic prev_ready;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.op       = 2'b00;
    bus.A        = '0;
    bus.B        = '0;
    bus.flush    = 1'b0;
    bus.out_ready = 1'b1;
    bus.hi_we    = 1'b0;
    bus.lo_we    = 1'b0;
    bus.wdata    = '0;
    repeat (2) @(posedge clk);
    #1;
    rst    = 1'b1;
    chk_en = 1'b1;
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_hi", bus.hi, 32'h0);
    chk("reset_lo", bus.lo, 32'h0);

    run_op(2'b00, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "mult");
    run_op(2'b01, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "multu");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_neg");

    // Completion held back by the consumer; MTHI must be ignored outside IDLE.
    bus.out_ready = 1'b0;
    run_op(2'b11, 32'd7, 32'd2, 32'd1, 32'd3, "divu");
    for (int i = 0; i < 5; i++) begin
      bus.hi_we = 1'b1;
      bus.wdata = 32'hAAAA;
      step();
      chk("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("bp_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("bp_hi", bus.hi, 32'd1);
    end
    bus.hi_we     = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("bp_release_hi", bus.hi, 32'd1);

    run_op(2'b11, 32'h1234, 32'h0, 32'h1234, 32'hFFFF_FFFF, "divu_by_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, "div_ovf");

    preload(32'h11, 32'h22);
    bus.in_valid = 1'b1;
    bus.op       = 2'b00;
    bus.A        = 32'd3;
    bus.B        = 32'd5;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_hi", bus.hi, 32'h11);
    chk("flush_lo", bus.lo, 32'h22);
    repeat (40) step();
    chk("flush_no_late_valid", {31'b0, bus.out_valid}, 32'd0);

    preload(32'h11, 32'h22);
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    repeat (9) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_hi", bus.hi, 32'h0);
    chk("midrst_lo", bus.lo, 32'h0);

    // Back-to-back: second request is held valid from right after the first accept.
    bus.in_valid = 1'b1;
    bus.op       = 2'b01;
    bus.A        = 32'd6;
    bus.B        = 32'd7;
    step();
    bus.op = 2'b11;
    bus.A  = 32'd100;
    bus.B  = 32'd7;
    for (int i = 0; i < 60; i++) begin
      step();
      if (bus.out_valid) break;
    end
    c1 = cyc;
    chk("b2b_first_valid", {31'b0, bus.out_valid}, 32'd1);
    chk("b2b_first_hi", bus.hi, 32'd0);
    chk("b2b_first_lo", bus.lo, 32'd42);
    acc_cyc = c1;
    for (int i = 0; i < 10; i++) begin
      prev_ready = bus.in_ready;
      step();
      if (prev_ready) begin
        acc_cyc = cyc;
        break;
      end
    end
    bus.in_valid = 1'b0;
    chk("b2b_accept_after_completion", {31'b0, (acc_cyc - c1) >= 2}, 32'd1);
    lat = 0;
    for (int i = 0; i < 60; i++) begin
      step();
      lat++;
      if (bus.out_valid) break;
    end
    chk("b2b_second_latency", 32'(lat), 32'd34);
    chk("b2b_second_hi", bus.hi, 32'd2);
    chk("b2b_second_lo", bus.lo, 32'd14);
    step();

    for (int i = 0; i < 6000; i++) begin
      rst           = ($urandom_range(0, 2999) != 0);
      bus.in_valid  = $urandom_range(0, 1) == 1;
      bus.op        = 2'($urandom_range(0, 3));
      bus.A         = pick_operand();
      bus.B         = pick_operand();
      bus.flush     = ($urandom_range(0, 199) == 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.hi_we     = ($urandom_range(0, 15) == 0);
      bus.lo_we     = ($urandom_range(0, 15) == 0);
      bus.wdata     = $urandom;
      step();
    end
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.hi_we     = 1'b0;
    bus.lo_we     = 1'b0;
    bus.out_ready = 1'b1;
    bus.flush     = 1'b1;
    step();
    bus.flush = 1'b0;
    repeat (3) step();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
Name: mul_div_unit

Overview:
- Multi-cycle multiply/divide unit in the execute stage, alongside the combinational ALU.
- Fed by the same A/B operand path as the ALU.
- Implements MIPS MULT/MULTU/DIV/DIVU into architectural HI/LO registers, plus MTHI/MTLO writes.
- HI/LO are read combinationally by writeback for MFHI/MFLO.
- Iterative radix-2 datapath with valid/ready handshakes, so the pipeline control can stall on it.

Parameters:
- DATA_WIDTH, 32, operand/result width. The unit is only required to be correct at 32.
- CNT_WIDTH, 6, iteration counter width. Must hold DATA_WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset.
- in_valid  input  1  operation request.
- in_ready  output  1  unit can accept; high exactly when state is IDLE.
- op  input  2  2'b00 MULT, 2'b01 MULTU, 2'b10 DIV, 2'b11 DIVU.
- A  input  DATA_WIDTH  multiplicand / dividend.
- B  input  DATA_WIDTH  multiplier / divisor.
- flush  input  1  abort any in-flight operation.
- out_valid  output  1  result written to HI/LO, awaiting consumption.
- out_ready  input  1  pipeline consumes the completion.
- hi_we  input  1  MTHI write strobe.
- lo_we  input  1  MTLO write strobe.
- wdata  input  DATA_WIDTH  MTHI/MTLO data.
- hi  output  DATA_WIDTH  HI register.
- lo  output  DATA_WIDTH  LO register.

Behaviour:
- Reset (rst low at a clock edge):
  - state=IDLE, hi=0, lo=0, out_valid=0, counter=0; in_ready=1 from the next cycle.
  - Reset has priority over every other input and aborts any in-flight operation.
- States: IDLE -> MUL or DIV -> FIX -> DONE -> IDLE.
- IDLE, accept when in_valid && in_ready:
  - Latch the sign of A and of B; signed ops only, unsigned ops treat both as 0.
  - Latch |A| and |B|, 32-bit magnitudes. |0x80000000| = 0x80000000 unsigned.
  - Latch op[1]; clear counter.
  - Go to MUL if op[1]=0, else DIV.
- MUL: shift-add on a 64-bit {acc,mplr} register, 32 iterations, one per cycle, then FIX.
- DIV: restoring shift-subtract producing a 32-bit quotient and remainder, 32 iterations, then FIX.
- FIX, single cycle:
  - MUL: negate the 64-bit product if the signs differ.
  - DIV: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Write the results: MUL gives hi=product[63:32], lo=product[31:0]; DIV gives lo=quotient, hi=remainder.
  - Set out_valid and go to DONE.
  - FIX runs for unsigned ops too, giving a fixed latency.
- Latency: out_valid is high after the 34th rising edge following the accepting edge (32 iterations + FIX).
- DONE:
  - out_valid held high while out_ready is low; in_ready=0.
  - When out_valid && out_ready at an edge: out_valid=0, next state IDLE.
  - No new op is accepted in that same cycle.
- Divide by zero (B==0, signed or unsigned): same latency; lo=32'hFFFF_FFFF, hi=A. No exception.
- Signed overflow (0x80000000 / 0xFFFFFFFF): lo=0x80000000, hi=0. This falls naturally out of the magnitude arithmetic.
- flush:
  - In MUL, DIV or FIX: next state IDLE, hi/lo unchanged, no out_valid.
  - In DONE: out_valid cleared, state to IDLE; hi/lo keep the completed result.
  - flush && in_valid in IDLE: request not accepted.
- MTHI/MTLO:
  - hi_we/lo_we take effect only in IDLE; they are ignored in all other states.
  - If a write and an accept happen in the same IDLE cycle, the write lands; the new operation later overwrites hi/lo at FIX.
- hi and lo are register outputs with no combinational path from the inputs. in_ready and out_valid depend only on state.

Decomposition:
- Shared header md_defs.vh holds:
  - op encodings MD_MULT/MD_MULTU/MD_DIV/MD_DIVU;
  - state encodings S_IDLE/S_MUL/S_DIV/S_FIX/S_DONE;
  - iteration count 32.
- One sub-module, md_step: a combinational single-iteration datapath.
  - Mode 0: conditional add and shift for multiply.
  - Mode 1: trial subtract, restore and shift for divide.
  - Instantiated once in mul_div_unit, which owns the FSM, counter, sign fixing and HI/LO.

Test Plan:
- Multiply: MULT A=0xFFFFFFFF, B=2 -> hi=0xFFFFFFFF, lo=0xFFFFFFFE, out_valid on the 34th edge after accept. MULTU with the same operands -> hi=0x00000001, lo=0xFFFFFFFE.
- Divide: DIV A=0xFFFFFFF9 (-7), B=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU A=7, B=2 -> lo=3, hi=1.
- Divide edge cases: DIVU A=0x1234, B=0 -> lo=0xFFFFFFFF, hi=0x1234. DIV A=0x80000000, B=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Backpressure: hold out_ready low 5 cycles after completion -> out_valid stays 1, in_ready stays 0, and hi_we with wdata=0xAAAA has no effect. Raise out_ready -> IDLE next cycle, in_ready=1.
- Flush and reset mid-operation:
  - Preload hi=0x11, lo=0x22 via MTHI/MTLO, start MULT 3*5, assert flush at iteration 10 -> no out_valid, hi=0x11, lo=0x22, in_ready=1 next cycle.
  - Repeat with rst low instead -> hi=lo=0.
- Back-to-back: accept MULTU 6*7 then DIVU 100/7, with out_ready tied high -> first completion hi=0, lo=42; second hi=2, lo=14; second accept no earlier than the cycle after the first completion.
